pan_mix_scheduler: RTL

//   Time-multiplexes one shared pan unit across N_VOICES voices per audio sample frame.
//   - On sample_tick: snapshots all voice samples and lr_weights.
//   - Issues one voice per cycle to the pan unit, accumulates returned left/right into a stereo mix.
//   - Sits between voice generators and the output/effects chain; owns the only pan instance.

---
 rtl/pan_mix_scheduler_if.sv | 41 ++++
 rtl/pan_mix_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pan_mix_scheduler_if.sv
// Bus between the voice side, the shared pan unit and the pan_mix_scheduler.
// The master modport is the environment: it drives the voices and the pan unit results.
// The slave modport is the scheduler itself.
// SAMPLE_WIDTH and FIXED_POINT get default values here when the build does not set them.
`ifndef SAMPLE_WIDTH
`define SAMPLE_WIDTH 32
`endif
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

interface pan_mix_scheduler_if #(
  parameter int N_VOICES = 8,
  parameter int WIDTH    = `SAMPLE_WIDTH,
  parameter int FRAC     = `FIXED_POINT
);
  localparam int OUT_W = WIDTH + FRAC;

  logic                              sample_tick;
  logic [N_VOICES-1:0][WIDTH-1:0]    voice_in;
  logic [N_VOICES-1:0][31:0]         weight_in;
  logic [WIDTH-1:0]                  pan_in;
  logic [31:0]                       pan_weight;
  logic signed [OUT_W-1:0]           pan_left;
  logic signed [OUT_W-1:0]           pan_right;
  logic signed [OUT_W-1:0]           mix_left;
  logic signed [OUT_W-1:0]           mix_right;
  logic                              mix_valid;
  logic                              busy;
  logic                              overrun;

  modport master (
    output sample_tick, voice_in, weight_in, pan_left, pan_right,
    input  pan_in, pan_weight, mix_left, mix_right, mix_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, voice_in, weight_in, pan_left, pan_right,
    output pan_in, pan_weight, mix_left, mix_right, mix_valid, busy, overrun
  );
endinterface

// File: rtl/pan_mix_scheduler.sv
// pan_mix_scheduler: time-multiplexes one shared pan unit across N_VOICES voices per frame.
// A tick snapshots every voice and weight. One voice is issued per cycle. The returned
// left/right values are summed into a stereo mix, and the mix is published with a 1-cycle
// mix_valid pulse.
// Optional feature: define PAN_MIX_SAT_EN to saturate the mix to the output range.
// Without it, the mix takes the low bits of the accumulator (two's-complement wrap).
`ifndef SAMPLE_WIDTH
`define SAMPLE_WIDTH 32
`endif
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

module pan_mix_scheduler #(
  parameter int N_VOICES    = 8,
  parameter int WIDTH       = `SAMPLE_WIDTH,
  parameter int PAN_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rstn,
  pan_mix_scheduler_if.slave bus
);
  localparam int OUT_W = WIDTH + `FIXED_POINT;
  localparam int ACC_W = OUT_W + $clog2(N_VOICES) + 1;
  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);
  // Every pipe stage except the output stage; the pipe is drained once these are all empty.
  localparam logic [PAN_LATENCY-1:0] KEEP_MASK = {PAN_LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                          state;
  state_t                          state_next;
  logic [IDX_W-1:0]                idx;
  logic [IDX_W-1:0]                idx_inc;
  logic [PAN_LATENCY-1:0]          tag_pipe;
  logic                            tag_out;
  logic [N_VOICES-1:0][WIDTH-1:0]  snap_voice;
  logic [N_VOICES-1:0][31:0]       snap_weight;
  logic signed [ACC_W-1:0]         acc_l;
  logic signed [ACC_W-1:0]         acc_r;
  logic signed [ACC_W-1:0]         acc_l_next;
  logic signed [ACC_W-1:0]         acc_r_next;
  logic [OUT_W-1:0]                mix_l_val;
  logic [OUT_W-1:0]                mix_r_val;
  logic                            accept;
  logic                            push_tag;
  logic                            drain_done;

  assign accept     = (state == IDLE) && bus.sample_tick;
  assign tag_out    = tag_pipe[PAN_LATENCY-1];
  assign drain_done = (tag_pipe & KEEP_MASK) == '0;
  assign idx_inc    = idx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: issue N voices, wait for the pan pipe to empty, publish
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.sample_tick) state_next = ISSUE;
      ISSUE: if (idx == LAST_IDX) state_next = DRAIN;
      DRAIN: if (drain_done)      state_next = DONE;
      DONE:                       state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state; a tick seen in DONE is therefore still "busy"
  always_comb begin
    push_tag      = (state == ISSUE);
    bus.busy      = (state != IDLE);
    bus.mix_valid = (state == DONE);
  end

  // Tag pipe runs alongside the pan unit and marks which of its outputs are real voices
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tag_pipe <= '0;
    else       tag_pipe <= (tag_pipe << 1) | PAN_LATENCY'(push_tag);
  end

  // Snapshot and issue: voice 0 goes out straight from the inputs, later voices come from the snapshot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_voice     <= '0;
      snap_weight    <= '0;
      idx            <= '0;
      bus.pan_in     <= '0;
      bus.pan_weight <= '0;
    end else if (accept) begin
      snap_voice     <= bus.voice_in;
      snap_weight    <= bus.weight_in;
      idx            <= '0;
      bus.pan_in     <= bus.voice_in[0];
      bus.pan_weight <= bus.weight_in[0];
    end else if (state == ISSUE && idx != LAST_IDX) begin
      idx            <= idx_inc;
      bus.pan_in     <= snap_voice[idx_inc];
      bus.pan_weight <= snap_weight[idx_inc];
    end
  end

  // Next accumulator values: add sign-extended pan results only when the tag marks a real voice
  always_comb begin
    acc_l_next = acc_l;
    acc_r_next = acc_r;
    if (tag_out) begin
      acc_l_next = acc_l + ACC_W'(bus.pan_left);
      acc_r_next = acc_r + ACC_W'(bus.pan_right);
    end
  end

  // Accumulators are cleared on an accepted tick so each frame starts from zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (accept) begin
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      acc_l <= acc_l_next;
      acc_r <= acc_r_next;
    end
  end

  // Narrow the final accumulator value to the mix width
  always_comb begin
`ifdef PAN_MIX_SAT_EN
    mix_l_val = acc_l_next[OUT_W-1:0];
    mix_r_val = acc_r_next[OUT_W-1:0];
    if (acc_l_next[ACC_W-1:OUT_W-1] != '0 && acc_l_next[ACC_W-1:OUT_W-1] != '1)
      mix_l_val = acc_l_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    if (acc_r_next[ACC_W-1:OUT_W-1] != '0 && acc_r_next[ACC_W-1:OUT_W-1] != '1)
      mix_r_val = acc_r_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`else
    mix_l_val = acc_l_next[OUT_W-1:0];
    mix_r_val = acc_r_next[OUT_W-1:0];
`endif
  end

  // Mix outputs load as the FSM enters DONE and hold until the next frame completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.mix_left  <= '0;
      bus.mix_right <= '0;
    end else if (state == DRAIN && drain_done) begin
      bus.mix_left  <= mix_l_val;
      bus.mix_right <= mix_r_val;
    end
  end

  // Sticky overrun flag: any tick that arrives while a frame is in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                  bus.overrun <= 1'b0;
    else if (bus.sample_tick && state != IDLE)  bus.overrun <= 1'b1;
  end
endmodule
